// File: rtl/fir_ster_fsm_if.sv
// Control/counter bus of the FIR run sequencer: run request, sizes, counter
// handshake and the per-sample datapath strobes.
interface fir_ster_fsm_if #(
  parameter int WSP_W = 6
);
  logic             start;
  logic             stop;
  logic [13:0]      ile_probek;
  logic [WSP_W-1:0] ile_wsp;
  logic             licznik_full;
  logic [14:0]      ile_razy;
  logic             FSM_zapisz_probki;
  logic             FSM_reset_licznik;
  logic             FSM_nowa_probka;
  logic [WSP_W-1:0] A_wsp;
  logic             FSM_mac_clr;
  logic             FSM_mac_en;
  logic             FSM_wyn_we;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, stop, ile_probek, ile_wsp, licznik_full,
    output ile_razy, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
           A_wsp, FSM_mac_clr, FSM_mac_en, FSM_wyn_we, busy, done, err
  );

  modport slave (
    output start, stop, ile_probek, ile_wsp, licznik_full,
    input  ile_razy, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
           A_wsp, FSM_mac_clr, FSM_mac_en, FSM_wyn_we, busy, done, err
  );
endinterface

// File: rtl/fir_ster_fsm.sv
// Control FSM for one FIR convolution run: counter strobes, coefficient address,
// MAC clear/enable/drain and output-RAM write, repeated per output sample.
module fir_ster_fsm #(
  parameter int WSP_W   = 6,
  parameter int MAC_LAT = 2
) (
  input logic            clk_b,
  input logic            rst,
  fir_ster_fsm_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CLR   = 3'd2;
  localparam logic [2:0] MAC   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] STEP  = 3'd5;
  localparam logic [2:0] WRITE = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_INIT = (MAC_LAT > 0) ? LAT_W'(MAC_LAT - 1) : LAT_ZERO;
  localparam logic [WSP_W-1:0] WSP_ZERO = {WSP_W{1'b0}};
  localparam logic [WSP_W-1:0] WSP_ONE  = WSP_W'(1);
  localparam logic [14:0]      RAZY_MAX = 15'd8192;

  // A run needs at least one sample and one coefficient and must fit a 13-bit counter address.
  function automatic logic start_ok(input logic [13:0] n, input logic [WSP_W-1:0] w,
                                    input logic [14:0] razy);
    start_ok = (n != 14'd0) && (w != WSP_ZERO) && (razy <= RAZY_MAX);
  endfunction

  logic [2:0]       state_r, state_s;
  logic [14:0]      razy_r, razy_s, suma_s;
  logic [WSP_W-1:0] wsp_r, wsp_s;
  logic [WSP_W-1:0] a_wsp_r, a_wsp_s;
  logic [LAT_W-1:0] lat_r, lat_s;
  logic             err_s, abort_s;
  logic             zapisz_r, rst_lic_r, nowa_r, clr_r, en_r, we_r, busy_r, done_r, err_r;

  assign suma_s = {1'b0, bus.ile_probek} + 15'(bus.ile_wsp) - 15'd1;

  // Next-state, run context and abort decode; stop overrides every transition outside IDLE.
  always_comb begin
    state_s = state_r;
    razy_s  = razy_r;
    wsp_s   = wsp_r;
    a_wsp_s = a_wsp_r;
    lat_s   = lat_r;
    err_s   = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (start_ok(bus.ile_probek, bus.ile_wsp, suma_s)) begin
            state_s = LOAD;
            razy_s  = suma_s;
            wsp_s   = bus.ile_wsp;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:  state_s = CLR;
      CLR: begin
        state_s = MAC;
        a_wsp_s = WSP_ZERO;
      end
      MAC: begin
        if (a_wsp_r == wsp_r - WSP_ONE) begin
          if (MAC_LAT == 0) begin
            state_s = STEP;
          end else begin
            state_s = DRAIN;
            lat_s   = LAT_INIT;
          end
        end else begin
          a_wsp_s = a_wsp_r + WSP_ONE;
        end
      end
      DRAIN: begin
        if (lat_r == LAT_ZERO) begin
          state_s = STEP;
        end else begin
          lat_s = lat_r - LAT_ONE;
        end
      end
      STEP:  state_s = WRITE;
      WRITE: begin
        if (bus.licznik_full) begin
          state_s = DONE;
        end else begin
          state_s = CLR;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (bus.stop && (state_r != IDLE)) begin
      state_s = IDLE;
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // State, run context and strobe registers; each strobe is decoded from the state being entered.
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      razy_r    <= 15'd0;
      wsp_r     <= WSP_ZERO;
      a_wsp_r   <= WSP_ZERO;
      lat_r     <= LAT_ZERO;
      zapisz_r  <= 1'b0;
      rst_lic_r <= 1'b0;
      nowa_r    <= 1'b0;
      clr_r     <= 1'b0;
      en_r      <= 1'b0;
      we_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      razy_r    <= razy_s;
      wsp_r     <= wsp_s;
      a_wsp_r   <= a_wsp_s;
      lat_r     <= lat_s;
      zapisz_r  <= (state_s == LOAD);
      rst_lic_r <= (state_s == LOAD) || abort_s;
      nowa_r    <= (state_s == STEP);
      clr_r     <= (state_s == CLR);
      en_r      <= (state_s == MAC);
      we_r      <= (state_s == WRITE);
      busy_r    <= (state_s != IDLE);
      done_r    <= (state_s == DONE);
      err_r     <= err_s;
    end
  end

  assign bus.ile_razy          = razy_r;
  assign bus.FSM_zapisz_probki = zapisz_r;
  assign bus.FSM_reset_licznik = rst_lic_r;
  assign bus.FSM_nowa_probka   = nowa_r;
  assign bus.A_wsp             = a_wsp_r;
  assign bus.FSM_mac_clr       = clr_r;
  assign bus.FSM_mac_en        = en_r;
  assign bus.FSM_wyn_we        = we_r;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.err               = err_r;
endmodule
